// File: rtl/data_memory_ctrl.sv
// Data memory for the RV32 load/store path: request/ready handshake, optional
// wait states, byte-lane stores, sign/zero-extended loads and access faults.

module data_memory_ctrl #(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_STATES = 0,
  parameter int INIT_ZERO   = 0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ,
  output logic        READY,
  input  logic        WE,
  input  logic [1:0]  SIZE,
  input  logic        UNS,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic        RVALID,
  output logic [31:0] RD,
  output logic        FAULT
);

  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_WAIT     = 2'd1;
  localparam logic [1:0]  ST_RESP     = 2'd2;
  localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit          HAS_WAIT    = (WAIT_STATES > 0);
  localparam logic [3:0]  WAIT_LOAD   = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);

  // The array has no reset; INIT_ZERO is only range-checked here.
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("data_memory_ctrl: WAIT_STATES must be in 0..15");
  end
  if (DEPTH_WORDS < 2 || IDX_W > 30) begin : g_bad_depth
    $error("data_memory_ctrl: DEPTH_WORDS out of supported range");
  end
  if (INIT_ZERO != 0 && INIT_ZERO != 1) begin : g_bad_init
    $error("data_memory_ctrl: INIT_ZERO must be 0 or 1");
  end

  function automatic logic access_fault_f(input logic [1:0] size, input logic [31:0] addr);
    logic bad_s;
    case (size)
      2'b00:   bad_s = 1'b0;
      2'b01:   bad_s = addr[0];
      2'b10:   bad_s = (addr[1:0] != 2'b00);
      default: bad_s = 1'b1;
    endcase
    return bad_s | (addr[31:2] >= DEPTH_LIMIT);
  endfunction

  function automatic logic [3:0] lane_enable_f(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] en_s;
    case (size)
      2'b00:   en_s = 4'b0001 << off;
      2'b01:   en_s = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   en_s = 4'b1111;
      default: en_s = 4'b0000;
    endcase
    return en_s;
  endfunction

  function automatic logic [31:0] lane_data_f(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] data_s;
    case (size)
      2'b00:   data_s = {4{wd[7:0]}};
      2'b01:   data_s = {2{wd[15:0]}};
      default: data_s = wd;
    endcase
    return data_s;
  endfunction

  function automatic logic [31:0] load_extend_f(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] res_s;
    case (off)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      default: byte_s = word[31:24];
    endcase
    half_s = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res_s = uns ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
      2'b01:   res_s = uns ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
      2'b10:   res_s = word;
      default: res_s = 32'd0;
    endcase
    return res_s;
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [3:0]       cnt_r;
  logic [3:0]       cnt_nxt_s;
  logic             go_resp_s;
  logic             accept_s;
  logic             we_r;
  logic [1:0]       size_r;
  logic             uns_r;
  logic [31:0]      addr_r;
  logic [31:0]      wd_r;
  logic             acc_we_s;
  logic [1:0]       acc_size_s;
  logic             acc_uns_s;
  logic [31:0]      acc_addr_s;
  logic [31:0]      acc_wd_s;
  logic             acc_fault_s;
  logic [IDX_W-1:0] acc_idx_s;
  logic [31:0]      mem_word_s;
  logic [3:0]       lane_en_s;
  logic [31:0]      lane_data_s;
  logic             rvalid_r;
  logic             fault_r;
  logic [31:0]      rd_r;
  logic [31:0]      mem_r [DEPTH_WORDS];

  assign READY    = RST_N & (state_r == ST_IDLE);
  assign accept_s = READY & REQ;
  assign RVALID   = rvalid_r;
  assign RD       = rd_r;
  assign FAULT    = fault_r;

  // Next-state and wait-counter decode; go_resp_s marks the edge that enters RESP.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    go_resp_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (REQ) begin
          if (HAS_WAIT) begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = WAIT_LOAD;
          end else begin
            state_nxt_s = ST_RESP;
            go_resp_s   = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_RESP;
          go_resp_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // With no wait states the access completes on the accept edge, so use live inputs then.
  always_comb begin
    if (state_r == ST_IDLE) begin
      acc_we_s   = WE;
      acc_size_s = SIZE;
      acc_uns_s  = UNS;
      acc_addr_s = A;
      acc_wd_s   = WD;
    end else begin
      acc_we_s   = we_r;
      acc_size_s = size_r;
      acc_uns_s  = uns_r;
      acc_addr_s = addr_r;
      acc_wd_s   = wd_r;
    end
  end

  assign acc_fault_s = access_fault_f(acc_size_s, acc_addr_s);
  assign acc_idx_s   = acc_addr_s[IDX_W+1:2];
  assign mem_word_s  = mem_r[acc_idx_s];
  assign lane_en_s   = lane_enable_f(acc_size_s, acc_addr_s[1:0]);
  assign lane_data_s = lane_data_f(acc_size_s, acc_wd_s);

  // Control state, request capture and registered response.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 4'd0;
      we_r     <= 1'b0;
      size_r   <= 2'b00;
      uns_r    <= 1'b0;
      addr_r   <= 32'd0;
      wd_r     <= 32'd0;
      rvalid_r <= 1'b0;
      fault_r  <= 1'b0;
      rd_r     <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (accept_s) begin
        we_r   <= WE;
        size_r <= SIZE;
        uns_r  <= UNS;
        addr_r <= A;
        wd_r   <= WD;
      end
      if (go_resp_s) begin
        rvalid_r <= 1'b1;
        fault_r  <= acc_fault_s;
        rd_r     <= (acc_fault_s || acc_we_s) ? 32'd0
                    : load_extend_f(mem_word_s, acc_size_s, acc_addr_s[1:0], acc_uns_s);
      end else begin
        rvalid_r <= 1'b0;
      end
    end
  end

  // Byte-lane store commit; reset on the same edge abandons the store.
  always_ff @(posedge CLK) begin
    if (RST_N && go_resp_s && acc_we_s && !acc_fault_s) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en_s[i]) begin
          mem_r[acc_idx_s][8*i +: 8] <= lane_data_s[8*i +: 8];
        end
      end
    end
  end

endmodule
